// File: rtl/tft_spi_tx.sv
// Byte-level SPI mode-0 serializer for a 4-wire TFT panel (SCK, MOSI, CS#, D/C).
// One byte per strobe: 8 SCK pulses, a CS# hold and a CS# gap, 18*CLK_DIV cycles total.
module tft_spi_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       global_reset,
    input  logic       tft_transmit,
    input  logic       tft_dc,
    input  logic [7:0] tft_data,
    output logic       tft_busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       spi_dc
);

    localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_div_cnt;
    logic [7:0]      r_shreg;
    logic [2:0]      r_bit_cnt;
    logic            r_sck;
    logic            r_cs_n;
    logic            r_dc;
    logic            w_div_done;

    assign w_div_done = (r_div_cnt == DIV_LAST);

    // MOSI is the top bit of the shift register, so it is a flop output and
    // only moves at accept or on the shift that coincides with SCK falling.
    assign spi_mosi = r_shreg[7];
    assign spi_sck  = r_sck;
    assign spi_cs_n = r_cs_n;
    assign spi_dc   = r_dc;
    assign tft_busy = global_reset | (r_state != S_IDLE) | tft_transmit;

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) r_state <= S_IDLE;
        else              r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (tft_transmit) w_state_next = S_LOW;
            S_LOW:  if (w_div_done)   w_state_next = S_HIGH;
            S_HIGH: if (w_div_done)   w_state_next = (r_bit_cnt == 3'd0) ? S_HOLD : S_LOW;
            S_HOLD: if (w_div_done)   w_state_next = S_GAP;
            S_GAP:  if (w_div_done)   w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            r_div_cnt <= '0;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_sck     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_dc      <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_state_next != r_state) r_div_cnt <= '0;
            else                                              r_div_cnt <= r_div_cnt + DW'(1);

            case (r_state)
                S_IDLE: begin
                    if (tft_transmit) begin
                        r_shreg   <= tft_data;
                        r_dc      <= tft_dc;
                        r_cs_n    <= 1'b0;
                        r_bit_cnt <= 3'd7;
                        r_sck     <= 1'b0;
                    end
                end
                S_LOW: begin
                    if (w_div_done) r_sck <= 1'b1;
                end
                S_HIGH: begin
                    if (w_div_done) begin
                        r_sck <= 1'b0;
                        if (r_bit_cnt != 3'd0) begin
                            r_shreg   <= {r_shreg[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_div_done) r_cs_n <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
